// File: rtl/sdram_req_arbiter_if.sv
// Bundle of the three master request/response channels and the shared SDRAM
// command port. The arbiter takes the slave view; masters and the controller take the master view.
interface sdram_req_arbiter_if #(
  parameter int ADDR_W = 21
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt, vga_rvalid, vga_done;

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_gnt, ic_rvalid, ic_done;

  logic              dc_req, dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [7:0]        dc_len;
  logic [3:0]        dc_mask;
  logic              dc_gnt, dc_rvalid, dc_done;

  logic [31:0]       rsp_rdata;

  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_len;
  logic [3:0]        mem_mask;
  logic              mem_ack, mem_rvalid, mem_done;
  logic [31:0]       mem_rdata;

  modport slave (
    input  vga_req, vga_addr, ic_req, ic_addr,
           dc_req, dc_we, dc_addr, dc_len, dc_mask,
           mem_ack, mem_rvalid, mem_rdata, mem_done,
    output vga_gnt, vga_rvalid, vga_done,
           ic_gnt, ic_rvalid, ic_done,
           dc_gnt, dc_rvalid, dc_done, rsp_rdata,
           mem_req, mem_we, mem_addr, mem_len, mem_mask
  );

  modport master (
    output vga_req, vga_addr, ic_req, ic_addr,
           dc_req, dc_we, dc_addr, dc_len, dc_mask,
           mem_ack, mem_rvalid, mem_rdata, mem_done,
    input  vga_gnt, vga_rvalid, vga_done,
           ic_gnt, ic_rvalid, ic_done,
           dc_gnt, dc_rvalid, dc_done, rsp_rdata,
           mem_req, mem_we, mem_addr, mem_len, mem_mask
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// Three-way SDRAM request arbiter: VGA first with a bounded streak, then
// round-robin between icache and dcache; one burst in flight at a time.
module sdram_req_arbiter #(
  parameter int         ADDR_W        = 21,
  parameter logic [7:0] FIX_LEN       = 8'd15,
  parameter int         VGA_BURST_MAX = 4
) (
  input  logic               sdram_clk,
  input  logic               reset_n,
  sdram_req_arbiter_if.slave bus
);
  localparam int STREAK_W = ($clog2(VGA_BURST_MAX + 1) > 3) ? $clog2(VGA_BURST_MAX + 1) : 3;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VGA_BURST_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [3:0]        mask;
  } cmd_t;

  state_e              state;
  cmd_t                cmd_q, win_cmd;
  // one-hot master vectors: bit 0 vga, bit 1 ic, bit 2 dc
  logic [2:0]          own_q, win_oh, gnt_q, rvalid_q, done_q;
  logic [STREAK_W-1:0] vga_streak;
  logic                last_is_dc;
  logic                mem_req_q;
  logic [31:0]         rdata_q;
  logic                cpu_pend, vga_blocked;

  always_comb begin
    cpu_pend    = bus.ic_req | bus.dc_req;
    vga_blocked = cpu_pend && (vga_streak == STREAK_MAX);
    win_oh      = 3'b000;
    if (bus.vga_req && !vga_blocked)   win_oh = 3'b001;
    else if (bus.ic_req && bus.dc_req) win_oh = last_is_dc ? 3'b010 : 3'b100;
    else if (bus.dc_req)               win_oh = 3'b100;
    else if (bus.ic_req)               win_oh = 3'b010;

    win_cmd = '{we: 1'b0, addr: bus.vga_addr, len: FIX_LEN, mask: 4'd0};
    if (win_oh[1]) win_cmd.addr = bus.ic_addr;
    if (win_oh[2]) win_cmd = '{we: bus.dc_we, addr: bus.dc_addr, len: bus.dc_len, mask: bus.dc_mask};
  end

  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd_q      <= '0;
      own_q      <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      done_q     <= '0;
      vga_streak <= '0;
      last_is_dc <= 1'b0;
      mem_req_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      done_q   <= '0;
      case (state)
        IDLE: if (|win_oh) begin
          state     <= ISSUE;
          own_q     <= win_oh;
          gnt_q     <= win_oh;
          cmd_q     <= win_cmd;
          mem_req_q <= 1'b1;
          if (win_oh[0]) begin
            // the streak only counts VGA wins that made a CPU master wait
            if (!cpu_pend)                    vga_streak <= '0;
            else if (vga_streak != STREAK_MAX) vga_streak <= vga_streak + 1'b1;
          end else begin
            vga_streak <= '0;
            last_is_dc <= win_oh[2];
          end
        end
        ISSUE: if (bus.mem_ack) begin
          mem_req_q <= 1'b0;
          if (bus.mem_done) begin
            done_q <= own_q;
            own_q  <= '0;
            state  <= IDLE;
          end else begin
            state  <= BUSY;
          end
        end
        BUSY: begin
          // a dcache write never returns data to its master
          if (bus.mem_rvalid && !(own_q[2] && cmd_q.we)) begin
            rdata_q  <= bus.mem_rdata;
            rvalid_q <= own_q;
          end
          if (bus.mem_done) begin
            done_q <= own_q;
            own_q  <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vga_gnt    = gnt_q[0];
  assign bus.ic_gnt     = gnt_q[1];
  assign bus.dc_gnt     = gnt_q[2];
  assign bus.vga_rvalid = rvalid_q[0];
  assign bus.ic_rvalid  = rvalid_q[1];
  assign bus.dc_rvalid  = rvalid_q[2];
  assign bus.vga_done   = done_q[0];
  assign bus.ic_done    = done_q[1];
  assign bus.dc_done    = done_q[2];
  assign bus.rsp_rdata  = rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = cmd_q.we;
  assign bus.mem_addr   = cmd_q.addr;
  assign bus.mem_len    = cmd_q.len;
  assign bus.mem_mask   = cmd_q.mask;
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Bench for sdram_req_arbiter: directed scenarios plus random masters and
// controller, all checked each cycle against a transaction-level model.
module tb_sdram_req_arbiter;
  localparam int ADDR_W = 21;
  localparam int VMAX   = 4;
  localparam int FIXL   = 15;

  logic sdram_clk = 1'b0;
  logic reset_n   = 1'b0;

  sdram_req_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  sdram_req_arbiter #(.ADDR_W(ADDR_W), .FIX_LEN(8'd15), .VGA_BURST_MAX(VMAX)) dut (
    .sdram_clk (sdram_clk),
    .reset_n   (reset_n),
    .bus       (bus.slave)
  );

  always #5 sdram_clk = ~sdram_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout_fail(string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  // m_st: 0 no burst, 1 command offered, 2 burst in progress
  int m_st, m_own, m_streak, m_last;
  logic [2:0]        e_gnt, e_rv, e_done;
  logic              e_mreq, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]        e_len;
  logic [3:0]        e_mask;
  logic [31:0]       e_rdata;
  int glog[$];
  int mlog[$];

  task automatic model_reset();
    m_st = 0; m_own = -1; m_streak = 0; m_last = 1;
    e_gnt = '0; e_rv = '0; e_done = '0; e_mreq = 0; e_we = 0;
    e_addr = '0; e_len = '0; e_mask = '0; e_rdata = '0;
  endtask

  task automatic model_step();
    bit r[3];
    bit cpu;
    int w;
    r[0] = bus.vga_req; r[1] = bus.ic_req; r[2] = bus.dc_req;
    e_gnt = '0; e_rv = '0; e_done = '0;
    if (m_st == 0) begin
      cpu = r[1] | r[2];
      w = -1;
      if (r[0] && !(m_streak == VMAX && cpu)) w = 0;
      else if (r[1] && r[2]) w = (m_last == 1) ? 2 : 1;
      else if (r[2]) w = 2;
      else if (r[1]) w = 1;
      if (w >= 0) begin
        if (w == 0) m_streak = cpu ? ((m_streak < VMAX) ? m_streak + 1 : VMAX) : 0;
        else begin m_streak = 0; m_last = w; end
        mlog.push_back(w);
        e_gnt[w] = 1'b1; e_mreq = 1'b1; m_own = w; m_st = 1;
        e_we   = (w == 2) ? bus.dc_we   : 1'b0;
        e_len  = (w == 2) ? bus.dc_len  : 8'(FIXL);
        e_mask = (w == 2) ? bus.dc_mask : 4'h0;
        e_addr = (w == 0) ? bus.vga_addr : (w == 1) ? bus.ic_addr : bus.dc_addr;
      end
    end else if (m_st == 1) begin
      if (bus.mem_ack) begin
        e_mreq = 1'b0;
        if (bus.mem_done) begin e_done[m_own] = 1'b1; m_own = -1; m_st = 0; end
        else m_st = 2;
      end
    end else begin
      if (bus.mem_rvalid && !(m_own == 2 && e_we)) begin
        e_rv[m_own] = 1'b1; e_rdata = bus.mem_rdata;
      end
      if (bus.mem_done) begin e_done[m_own] = 1'b1; m_own = -1; m_st = 0; end
    end
  endtask

  task automatic compare();
    logic [2:0] g, rv, d;
    g  = {bus.dc_gnt,    bus.ic_gnt,    bus.vga_gnt};
    rv = {bus.dc_rvalid, bus.ic_rvalid, bus.vga_rvalid};
    d  = {bus.dc_done,   bus.ic_done,   bus.vga_done};
    for (int i = 0; i < 3; i++) if (g[i]) glog.push_back(i);
    check("gnt",       g,             e_gnt);
    check("rvalid",    rv,            e_rv);
    check("done",      d,             e_done);
    check("mem_req",   bus.mem_req,   e_mreq);
    check("mem_we",    bus.mem_we,    e_we);
    check("mem_addr",  bus.mem_addr,  e_addr);
    check("mem_len",   bus.mem_len,   e_len);
    check("mem_mask",  bus.mem_mask,  e_mask);
    check("rsp_rdata", bus.rsp_rdata, e_rdata);
  endtask

  // one clock: model advances on the edge, DUT is compared on the falling edge
  task automatic tick();
    @(posedge sdram_clk);
    if (reset_n) model_step();
    @(negedge sdram_clk);
    compare();
  endtask

  task automatic clear_inputs();
    bus.vga_req = 0; bus.vga_addr = '0;
    bus.ic_req  = 0; bus.ic_addr  = '0;
    bus.dc_req  = 0; bus.dc_we = 0; bus.dc_addr = '0; bus.dc_len = '0; bus.dc_mask = '0;
    bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0; bus.mem_done = 0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, " gnt"},    {bus.dc_gnt, bus.ic_gnt, bus.vga_gnt}, 3'b000);
    check({tag, " rvalid"}, {bus.dc_rvalid, bus.ic_rvalid, bus.vga_rvalid}, 3'b000);
    check({tag, " done"},   {bus.dc_done, bus.ic_done, bus.vga_done}, 3'b000);
    check({tag, " cmd"},    {bus.mem_req, bus.mem_we, bus.mem_len, bus.mem_mask}, 14'h0);
    check({tag, " addr"},   bus.mem_addr, 21'h0);
    check({tag, " rdata"},  bus.rsp_rdata, 32'h0);
  endtask

  // called at a falling edge; leaves reset released at a falling edge
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_all_zero("async reset");
    model_reset();
    clear_inputs();
    tick();
    reset_n = 1'b1;
  endtask

  // acts as the controller for one burst, requesters left as they are
  task automatic serve(int nbeats, int ack_wait);
    int t = 0;
    while (!bus.mem_req && t < 20) begin tick(); t++; end
    if (!bus.mem_req) begin timeout_fail("serve mem_req"); return; end
    repeat (ack_wait) tick();
    bus.mem_ack = 1; tick(); bus.mem_ack = 0;
    for (int b = 0; b < nbeats; b++) begin
      bus.mem_rvalid = !bus.mem_we;
      bus.mem_rdata  = $urandom;
      bus.mem_done   = (b == nbeats - 1);
      tick();
    end
    bus.mem_rvalid = 0; bus.mem_done = 0;
  endtask

  task automatic check_log(string name, int exp[]);
    check({name, " dut count"},   glog.size(), exp.size());
    check({name, " model count"}, mlog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < glog.size() && i < mlog.size(); i++) begin
      check({name, " dut order"},   glog[i], exp[i]);
      check({name, " model order"}, mlog[i], exp[i]);
    end
  endtask

  bit ctl_busy = 0;

  task automatic drive_random();
    if (!bus.vga_req) begin
      if ($urandom % 4 == 0) begin bus.vga_req = 1; bus.vga_addr = ADDR_W'($urandom); end
    end else if (bus.vga_done && $urandom % 4 != 0) bus.vga_req = 0;
    if (!bus.ic_req) begin
      if ($urandom % 5 == 0) begin bus.ic_req = 1; bus.ic_addr = ADDR_W'($urandom); end
    end else if (bus.ic_done && $urandom % 4 != 0) bus.ic_req = 0;
    if (!bus.dc_req) begin
      if ($urandom % 5 == 0) begin
        bus.dc_req = 1; bus.dc_addr = ADDR_W'($urandom); bus.dc_we = 1'($urandom);
        bus.dc_len = 8'($urandom); bus.dc_mask = 4'($urandom);
      end
    end else if (bus.dc_done && $urandom % 4 != 0) bus.dc_req = 0;

    bus.mem_ack = 0; bus.mem_done = 0; bus.mem_rvalid = 0; bus.mem_rdata = $urandom;
    if (ctl_busy) begin
      bus.mem_rvalid = !bus.mem_we && ($urandom % 3 != 0);
      if ($urandom % 6 == 0) begin bus.mem_done = 1; ctl_busy = 0; end
    end else if (bus.mem_req) begin
      if ($urandom % 3 == 0) begin
        bus.mem_ack = 1;
        if ($urandom % 5 == 0) bus.mem_done = 1;
        else ctl_busy = 1;
      end else begin
        // stray beats/completions before the ack must be ignored
        bus.mem_rvalid = ($urandom % 6 == 0);
        bus.mem_done   = ($urandom % 10 == 0);
      end
    end else begin
      bus.mem_rvalid = ($urandom % 12 == 0);
      bus.mem_done   = ($urandom % 16 == 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(negedge sdram_clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // single icache read: ack after two waits, 16 beats, done with the last
    bus.ic_req = 1; bus.ic_addr = 21'h00100;
    tick();
    check("ic gnt",     bus.ic_gnt,   1);
    check("ic mem_req", bus.mem_req,  1);
    check("ic len",     bus.mem_len,  15);
    check("ic we",      bus.mem_we,   0);
    check("ic addr",    bus.mem_addr, 21'h00100);
    tick();
    check("ic gnt pulse", bus.ic_gnt, 0);
    tick();
    bus.mem_ack = 1; tick(); bus.mem_ack = 0;
    check("ic mem_req drop", bus.mem_req, 0);
    for (int i = 0; i < 16; i++) begin
      bus.mem_rvalid = 1; bus.mem_rdata = i; bus.mem_done = (i == 15);
      tick();
      check("ic beat rvalid", {bus.dc_rvalid, bus.ic_rvalid, bus.vga_rvalid}, 3'b010);
      check("ic beat data",   bus.rsp_rdata, i);
      check("ic done",        bus.ic_done, (i == 15));
    end
    bus.mem_rvalid = 0; bus.mem_done = 0; bus.ic_req = 0;
    tick();
    check("ic idle", bus.mem_req, 0);

    // dcache write
    bus.dc_req = 1; bus.dc_we = 1; bus.dc_len = 3; bus.dc_mask = 4'b0011; bus.dc_addr = 21'h1abcd;
    tick();
    check("dc gnt",  bus.dc_gnt,   1);
    check("dc we",   bus.mem_we,   1);
    check("dc len",  bus.mem_len,  3);
    check("dc mask", bus.mem_mask, 4'b0011);
    check("dc addr", bus.mem_addr, 21'h1abcd);
    bus.mem_ack = 1; tick(); bus.mem_ack = 0;
    tick(); tick();
    bus.mem_done = 1; tick(); bus.mem_done = 0;
    check("dc wr done",   bus.dc_done,   1);
    check("dc wr rvalid", bus.dc_rvalid, 0);
    bus.dc_req = 0; bus.dc_we = 0;
    tick();

    // ack+done together, then turnaround, then done with the last beat
    bus.vga_req = 1; bus.vga_addr = 21'h00400;
    tick();
    check("vga gnt", bus.vga_gnt, 1);
    bus.mem_ack = 1; bus.mem_done = 1; tick(); bus.mem_ack = 0; bus.mem_done = 0;
    check("ackdone done",    bus.vga_done, 1);
    check("ackdone mem_req", bus.mem_req,  0);
    tick();
    check("turnaround mem_req", bus.mem_req, 1);
    check("turnaround gnt",     bus.vga_gnt, 1);
    bus.mem_ack = 1; tick(); bus.mem_ack = 0;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h1111_0000; tick();
    bus.mem_rdata = 32'h2222_0001; bus.mem_done = 1; tick();
    bus.mem_rvalid = 0; bus.mem_done = 0;
    check("last beat rvalid", bus.vga_rvalid, 1);
    check("last beat done",   bus.vga_done,   1);
    check("last beat data",   bus.rsp_rdata,  32'h2222_0001);
    bus.vga_req = 0;
    tick();
    check("after last idle", bus.mem_req, 0);

    // ic/dc contention from reset: dc wins the first tie
    do_reset();
    glog.delete(); mlog.delete();
    bus.ic_req = 1; bus.ic_addr = 21'h00200;
    bus.dc_req = 1; bus.dc_we = 0; bus.dc_len = 1; bus.dc_addr = 21'h00300;
    repeat (4) serve(2, 0);
    bus.ic_req = 0; bus.dc_req = 0;
    tick(); tick();
    check_log("contention", '{2, 1, 2, 1});

    // VGA streak bound with dc waiting
    glog.delete(); mlog.delete();
    bus.vga_req = 1; bus.vga_addr = 21'h00500;
    bus.dc_req = 1; bus.dc_we = 0; bus.dc_len = 0; bus.dc_addr = 21'h00600;
    repeat (10) serve(1, 0);
    bus.vga_req = 0; bus.dc_req = 0;
    tick(); tick();
    check_log("vga bound", '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2});
    check("model streak after dc", m_streak, 0);

    // reset in the middle of a 16-beat burst, then a stale beat
    bus.vga_req = 1; bus.vga_addr = 21'h00700;
    tick();
    bus.mem_ack = 1; tick(); bus.mem_ack = 0;
    for (int i = 0; i < 7; i++) begin
      bus.mem_rvalid = 1; bus.mem_rdata = 32'hA0 + i; tick();
    end
    check("pre-reset rvalid", bus.vga_rvalid, 1);
    bus.mem_rdata = 32'hA7;
    do_reset();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD;
    tick();
    check("stale rvalid", {bus.dc_rvalid, bus.ic_rvalid, bus.vga_rvalid}, 3'b000);
    check("stale rdata",  bus.rsp_rdata, 32'h0);
    bus.mem_rvalid = 0; bus.vga_req = 1; bus.vga_addr = 21'h00800;
    tick();
    check("post-reset gnt",  bus.vga_gnt,  1);
    check("post-reset addr", bus.mem_addr, 21'h00800);
    serve(4, 1);
    bus.vga_req = 0;
    tick();

    // randomized traffic
    ctl_busy = 0;
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
